// File: rtl/synth_env_pkg.sv
// rtl/synth_env_pkg.sv - shared envelope defaults and state encoding for attack/decay stages
package synth_env_pkg;

    localparam int ENV_WIDTH   = 20;
    localparam int ENV_SHIFT_W = 5;

    typedef enum logic [1:0] {
        ENV_IDLE = 2'd0,
        ENV_RAMP = 2'd1,
        ENV_DONE = 2'd2,
        ENV_HOLD = 2'd3
    } env_state_e;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - one-clk pulse on each rising edge of a slow level sampled as data
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/attack.sv
// rtl/attack.sv - attack envelope: shift attenuation stepped down once per slow-clock tick
module attack
    import synth_env_pkg::*;
#(
    parameter int WIDTH   = ENV_WIDTH,
    parameter int SHIFT_W = ENV_SHIFT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk_d,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHIFT_W-1:0] attack_amount,
    input  logic               start,
    output logic [WIDTH-1:0]   out,
    output logic [SHIFT_W-1:0] shift_amount,
    output logic               start_decay,
    output logic               busy
);

    env_state_e         state_q, state_d;
    logic [SHIFT_W-1:0] scalar_q, scalar_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               tick;

    rise_detect u_rise_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (clk_d),
        .pulse   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ENV_IDLE;
            scalar_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            scalar_q <= scalar_d;
            out_q    <= out_d;
        end
    end

    // A logical shift by WIDTH or more already yields zero, so large attack amounts need no clamp.
    always_comb begin
        state_d  = state_q;
        scalar_d = scalar_q;
        out_d    = '0;
        case (state_q)
            ENV_IDLE: begin
                out_d = '0;
            end
            ENV_RAMP: begin
                out_d = in >> scalar_q;
                if (tick) begin
                    if (scalar_q == '0) begin
                        state_d = ENV_DONE;
                    end else begin
                        scalar_d = scalar_q - 1'b1;
                    end
                end
            end
            ENV_DONE: begin
                out_d   = in >> scalar_q;
                state_d = ENV_HOLD;
            end
            ENV_HOLD: begin
                out_d    = in;
                scalar_d = '0;
            end
            default: begin
                state_d = ENV_IDLE;
            end
        endcase
        // Retrigger from any state; a coincident tick is dropped.
        if (start) begin
            scalar_d = attack_amount;
            state_d  = ENV_RAMP;
        end
    end

    assign out          = out_q;
    assign shift_amount = scalar_q;
    assign busy         = (state_q == ENV_RAMP);
    assign start_decay  = (state_q == ENV_DONE) && !start;

endmodule

// File: tb/tb_attack.sv
// tb/tb_attack.sv - self-checking bench for the attack envelope stage
module tb_attack;

    localparam int W  = 20;
    localparam int SW = 5;
    localparam int P_IDLE = 0;
    localparam int P_RAMP = 1;
    localparam int P_DONE = 2;
    localparam int P_HOLD = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clk_d;
    logic [W-1:0]  in_s;
    logic [SW-1:0] amt;
    logic          start;
    logic [W-1:0]  out_s;
    logic [SW-1:0] shift;
    logic          sd;
    logic          busy;

    int errors = 0;
    int checks = 0;

    int           m_phase;
    int           m_scalar;
    logic [W-1:0] m_out;
    logic         m_clkd_prev;

    typedef struct {
        logic [W-1:0]  vin;
        logic [SW-1:0] vamt;
        logic [W-1:0]  vexp;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    attack #(.WIDTH(W), .SHIFT_W(SW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clk_d         (clk_d),
        .in            (in_s),
        .attack_amount (amt),
        .start         (start),
        .out           (out_s),
        .shift_amount  (shift),
        .start_decay   (sd),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Attenuation by 2**s expressed as division; shifts past the sample width silence it.
    function automatic logic [W-1:0] atten(input logic [W-1:0] x, input int s);
        if (s >= W) return '0;
        return W'(32'(x) / (32'd1 << s));
    endfunction

    task automatic step();
        int           np;
        int           ns;
        logic [W-1:0] no;
        logic         tk;
        np = m_phase;
        ns = m_scalar;
        tk = clk_d && !m_clkd_prev;
        if (m_phase == P_IDLE)      no = '0;
        else if (m_phase == P_HOLD) no = in_s;
        else                        no = atten(in_s, m_scalar);
        if (start) begin
            np = P_RAMP;
            ns = int'(amt);
        end else if (m_phase == P_RAMP && tk) begin
            if (m_scalar == 0) np = P_DONE;
            else               ns = m_scalar - 1;
        end else if (m_phase == P_DONE) begin
            np = P_HOLD;
        end
        @(posedge clk);
        #1;
        m_phase     = np;
        m_scalar    = ns;
        m_out       = no;
        m_clkd_prev = clk_d;
        check("model_out", 32'(out_s), 32'(m_out));
        check("model_shift", 32'(shift), 32'(m_scalar));
        check("model_busy", 32'(busy), 32'(m_phase == P_RAMP));
        check("model_start_decay", 32'(sd), 32'(m_phase == P_DONE && !start));
    endtask

    task automatic model_reset();
        m_phase     = P_IDLE;
        m_scalar    = 0;
        m_out       = '0;
        m_clkd_prev = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0]  sh_q[$];
        logic [W-1:0]   o_q[$];
        logic [SW-1:0]  last_sh;
        logic [W-1:0]   last_out;
        logic [SW-1:0]  exp_sh[5];
        logic [W-1:0]   exp_out[5];
        int             pulses;
        bit             seen;
        int             prev_shift;
        bit             prev_busy;

        vecs[0] = '{20'h80000, 5'd4,  20'h08000};
        vecs[1] = '{20'hFFFFF, 5'd25, 20'h00000};
        vecs[2] = '{20'hFFFFF, 5'd19, 20'h00001};
        vecs[3] = '{20'hFFFFF, 5'd20, 20'h00000};
        vecs[4] = '{20'h12345, 5'd0,  20'h12345};
        vecs[5] = '{20'hFFFFF, 5'd1,  20'h7FFFF};
        vecs[6] = '{20'hABCDE, 5'd8,  20'h00ABC};
        exp_sh  = '{5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
        exp_out = '{20'h08000, 20'h10000, 20'h20000, 20'h40000, 20'h80000};

        clk_d = 1'b0; in_s = '0; amt = '0; start = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #3;
        check("reset_out", 32'(out_s), 0);
        check("reset_shift", 32'(shift), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_start_decay", 32'(sd), 0);
        do_reset();

        // Table: after a start with no ticks, out settles at in >> attack_amount.
        for (int i = 0; i < 7; i++) begin
            in_s = vecs[i].vin; amt = vecs[i].vamt; start = 1'b1;
            step();
            start = 1'b0;
            step();
            check("vec_out", 32'(out_s), 32'(vecs[i].vexp));
            check("vec_shift", 32'(shift), 32'(vecs[i].vamt));
            check("vec_busy", 32'(busy), 1);
        end

        // Full ramp with clk_d period of 8 clk.
        do_reset();
        in_s = 20'h80000; amt = 5'd4; clk_d = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        last_sh = shift; sh_q.push_back(shift);
        last_out = out_s; pulses = 0;
        for (int k = 0; k < 80; k++) begin
            clk_d = ((k % 8) >= 4);
            step();
            if (shift != last_sh) sh_q.push_back(shift);
            if (out_s != last_out && out_s != '0) o_q.push_back(out_s);
            if (sd) pulses++;
            last_sh = shift; last_out = out_s;
        end
        check("ramp_shift_count", 32'(sh_q.size()), 5);
        check("ramp_out_count", 32'(o_q.size()), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < sh_q.size()) check("ramp_shift_seq", 32'(sh_q[k]), 32'(exp_sh[k]));
            if (k < o_q.size())  check("ramp_out_seq", 32'(o_q[k]), 32'(exp_out[k]));
        end
        check("ramp_decay_pulses", 32'(pulses), 1);

        // Zero attack: out follows in immediately, decay on the first tick, then hold.
        in_s = 20'h5A5A5; amt = 5'd0; clk_d = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("zero_out", 32'(out_s), 32'h5A5A5);
        clk_d = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (sd) seen = 1'b1;
        end
        check("zero_decay_seen", 32'(seen), 1);
        in_s = 20'h13579;
        step();
        step();
        check("hold_out", 32'(out_s), 32'h13579);
        check("hold_busy", 32'(busy), 0);

        // Large attack: silent while the shift is >= width, half scale at shift 1.
        in_s = 20'hFFFFF; amt = 5'd25; clk_d = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        prev_shift = int'(shift); prev_busy = busy; seen = 1'b0;
        for (int k = 0; k < 200 && (busy || k == 0); k++) begin
            clk_d = ((k % 4) >= 2);
            step();
            if (prev_busy && prev_shift >= W) check("sat_zero", 32'(out_s), 0);
            if (prev_busy && prev_shift == 1) begin
                check("half_scale", 32'(out_s), 32'h7FFFF);
                seen = 1'b1;
            end
            prev_shift = int'(shift); prev_busy = busy;
        end
        check("half_scale_seen", 32'(seen), 1);

        // Retrigger at shift 2.
        in_s = 20'h40000; amt = 5'd4; clk_d = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            clk_d = ((k % 4) >= 2);
            step();
            if (shift == 5'd2) seen = 1'b1;
        end
        check("retrig_reached_2", 32'(seen), 1);
        amt = 5'd6; start = 1'b1;
        step();
        check("retrig_shift", 32'(shift), 6);
        check("retrig_busy", 32'(busy), 1);
        check("retrig_no_decay", 32'(sd), 0);
        start = 1'b0; amt = 5'd3;
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            clk_d = ((k % 4) >= 2);
            step();
            if (sd) pulses++;
        end
        check("retrig_decay_pulses", 32'(pulses), 1);

        // Start coincident with a clk_d rising edge.
        clk_d = 1'b0;
        step();
        amt = 5'd7; start = 1'b1; clk_d = 1'b1;
        step();
        check("start_beats_tick", 32'(shift), 7);
        start = 1'b0;

        // Asynchronous reset in the middle of a ramp.
        in_s = 20'hFFFFF; amt = 5'd5; clk_d = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            clk_d = ((k % 4) >= 2);
            step();
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midreset_out", 32'(out_s), 0);
        check("midreset_shift", 32'(shift), 0);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_start_decay", 32'(sd), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 24; k++) begin
            clk_d = ((k % 4) >= 2);
            step();
            if (sd) pulses++;
        end
        check("midreset_no_pulse", 32'(pulses), 0);

        // Random traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            start = ($urandom_range(0, 24) == 0);
            if (start) amt = SW'($urandom_range(0, 31));
            in_s = W'($urandom);
            if ($urandom_range(0, 2) == 0) clk_d = ~clk_d;
            step();
        end
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/attack.md
ATTACK -- requirements
Module: attack

Interface
REQ-001 Parameter WIDTH, default 20, sample width of in/out.
REQ-002 Parameter SHIFT_W, default 5, width of attack_amount/shift_amount.
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 clk_d  input  1  slow rate clock, sampled in clk domain; each rising edge is one attack step.
REQ-006 in  input  WIDTH  unsigned sample amplitude to be enveloped.
REQ-007 attack_amount  input  SHIFT_W  initial attenuation shift (attack length in steps).
REQ-008 start  input  1  note-on trigger, level-sampled on clk.
REQ-009 out  output  WIDTH  registered enveloped sample.
REQ-010 shift_amount  output  SHIFT_W  current attenuation shift.
REQ-011 start_decay  output  1  one-clk pulse handing off to the decay stage.
REQ-012 busy  output  1  high while in RAMP.

Function
REQ-013 clk_d SHALL be registered once (clk_d_q); tick = clk_d & ~clk_d_q, one clk cycle per clk_d rising edge.
REQ-014 States SHALL be IDLE, RAMP, DONE, HOLD.
REQ-015 IDLE: out <= 0, shift_amount holds value; start=1 -> scalar <= attack_amount, go RAMP.
REQ-016 RAMP: on tick with scalar != 0, scalar <= scalar - 1; on tick with scalar == 0, go DONE.
REQ-017 RAMP and DONE: out <= in >> scalar every clk (one-cycle latency from in/scalar to out).
REQ-018 Shift values >= WIDTH SHALL yield out = 0 (no wrap, no clamp of scalar).
REQ-019 scalar SHALL never decrement below 0.
REQ-020 DONE lasts exactly one clk; start_decay = 1 only in DONE; then go HOLD.
REQ-021 HOLD: out <= in (full amplitude), scalar = 0, until next start.
REQ-022 start=1 in RAMP, DONE or HOLD SHALL retrigger: scalar <= attack_amount, go RAMP, no start_decay pulse that cycle.
REQ-023 start and tick in same cycle: start wins, tick discarded.
REQ-024 attack_amount sampled only on the start cycle; later changes ignored until retrigger.
REQ-025 attack_amount = 0: RAMP -> DONE on first tick; out = in throughout RAMP.
REQ-026 busy = 1 exactly when state is RAMP.
REQ-027 shift_amount SHALL equal scalar combinationally from the register.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE, scalar 0, clk_d_q 0, out 0, start_decay 0, busy 0.
REQ-029 Reset asserted mid-RAMP SHALL abort with no start_decay pulse; release returns to IDLE awaiting start.
REQ-030 First tick after reset release SHALL be detected only from a 0->1 clk_d transition seen after release.

Structure
REQ-031 Shared package synth_env_pkg SHALL hold WIDTH/SHIFT_W defaults and the state enumeration, shared with the decay stage.
REQ-032 One sub-module rise_detect (clk, reset_n, d -> pulse) SHALL implement REQ-013.
REQ-033 Single clock domain; no gated or derived clocks; clk_d used as data only.

Verification
REQ-034 in=0x80000, attack_amount=4, start 1 cycle, clk_d period 8 clk -> shift_amount 4,3,2,1,0 per tick; out 0x08000,0x10000,0x20000,0x40000,0x80000; start_decay one pulse after 5th tick.
REQ-035 attack_amount=0, start -> out=in one clk later; start_decay pulse on first tick; then HOLD out=in.
REQ-036 attack_amount=25, in=0xFFFFF -> out=0 while scalar>=20; out=0x7FFFF at scalar 1.
REQ-037 Retrigger at scalar=2 with attack_amount=6 -> shift_amount=6 next cycle, busy stays 1, no start_decay pulse.
REQ-038 start and clk_d rising edge same cycle -> shift_amount=attack_amount, not attack_amount-1.
REQ-039 reset_n low mid-RAMP -> out, shift_amount, busy, start_decay all 0 immediately, no pulse after release.
